// File: rtl/stencil_window_if.sv
// Handshake bundle for the streaming 3x3 stencil window generator.
// The slave modport is the generator side: it takes pixels in and drives windows out.
// The master modport is the environment side: it feeds pixels and consumes windows.
// out_sum exists only when STENCIL_SUM_EN is defined.
interface stencil_window_if #(
    parameter int PIX_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [PIX_W-1:0]   in_pixel;
    logic               out_valid;
    logic               out_ready;
    logic [9*PIX_W-1:0] out_win;
    logic [15:0]        out_x;
    logic [15:0]        out_y;
    logic               frame_done;
`ifdef STENCIL_SUM_EN
    logic [PIX_W+3:0]   out_sum;

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_win, out_x, out_y, frame_done, out_sum
    );

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_win, out_x, out_y, frame_done, out_sum
    );
`else
    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_win, out_x, out_y, frame_done
    );

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_win, out_x, out_y, frame_done
    );
`endif
endinterface

// File: rtl/stencil_window_gen.sv
// Streaming 3x3 stencil window generator.
// Pixels arrive in raster order; two line buffers hold the previous two rows and
// three column registers hold the newest columns, so every interior pixel yields a
// full 3x3 window one cycle after its bottom-right pixel is accepted.
// Optional feature macro: STENCIL_SUM_EN adds out_sum, the registered sum of the
// nine window pixels, aligned with out_win.
module stencil_window_gen #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    stencil_window_if.slave  bus
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int SW = PIX_W + 4;

    localparam logic [1:0] FILL = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] LAST = 2'd2;

    logic [1:0]       state;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;

    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];

    // Column registers indexed by row: [0] is row y-2, [1] row y-1, [2] row y.
    // col1 holds column x-1 and col2 holds column x-2 of the current row band.
    logic [PIX_W-1:0] col1 [3];
    logic [PIX_W-1:0] col2 [3];
    logic [PIX_W-1:0] col_new [3];

    logic             pass_ready;
    logic             accept;
    logic             transfer;
    logic             load;
    logic             x_last;
    logic             y_last;
    logic [9*PIX_W-1:0] win_next;

`ifdef STENCIL_SUM_EN
    logic [SW-1:0]    sum_next;
`endif

    // Input side is open unless a window is stuck at the output or the frame is closing.
    assign pass_ready    = (state != LAST) && (!bus.out_valid || bus.out_ready);
    assign bus.in_ready  = rst || pass_ready;
    assign accept        = bus.in_valid && pass_ready;
    assign transfer      = bus.out_valid && bus.out_ready;
    assign x_last        = (x == XW'(IMG_W - 1));
    assign y_last        = (y == YW'(IMG_H - 1));
    assign load          = accept && (x >= XW'(2)) && (y >= YW'(2));
    assign bus.frame_done = !rst && (state == LAST) && transfer;

    // Newest column: two buffered rows above the incoming pixel at the same x.
    always_comb begin
        col_new[0] = lb0[x];
        col_new[1] = lb1[x];
        col_new[2] = bus.in_pixel;
    end

    // Assemble the candidate window; slot 3*r+c, c=0 is the oldest column.
    always_comb begin
        win_next = '0;
        for (int r = 0; r < 3; r++) begin
            win_next[PIX_W*(3*r+0) +: PIX_W] = col2[r];
            win_next[PIX_W*(3*r+1) +: PIX_W] = col1[r];
            win_next[PIX_W*(3*r+2) +: PIX_W] = col_new[r];
        end
    end

`ifdef STENCIL_SUM_EN
    // Adder tree over the nine candidate pixels, wide enough to never overflow.
    always_comb begin
        sum_next = '0;
        for (int r = 0; r < 3; r++) begin
            sum_next = sum_next + SW'(col2[r]) + SW'(col1[r]) + SW'(col_new[r]);
        end
    end
`endif

    // Line buffers and column registers; contents are always written before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[x] <= lb1[x];
            lb1[x] <= bus.in_pixel;
            for (int r = 0; r < 3; r++) begin
                col2[r] <= col1[r];
                col1[r] <= col_new[r];
            end
        end
    end

    // Raster position counters and frame-phase state.
    always_ff @(posedge clk) begin
        if (rst) begin
            x     <= '0;
            y     <= '0;
            state <= FILL;
        end else begin
            if (accept) begin
                if (x_last) begin
                    x <= '0;
                    y <= y_last ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
            case (state)
                FILL: if (accept && (x == XW'(1)) && (y == YW'(2))) state <= RUN;
                RUN:  if (accept && x_last && y_last) state <= LAST;
                LAST: if (transfer) state <= FILL;
                default: state <= FILL;
            endcase
        end
    end

    // Output register: loads a new window, otherwise drops valid once it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_win   <= '0;
            bus.out_x     <= '0;
            bus.out_y     <= '0;
`ifdef STENCIL_SUM_EN
            bus.out_sum   <= '0;
`endif
        end else if (load) begin
            bus.out_valid <= 1'b1;
            bus.out_win   <= win_next;
            bus.out_x     <= 16'(x) - 16'd1;
            bus.out_y     <= 16'(y) - 16'd1;
`ifdef STENCIL_SUM_EN
            bus.out_sum   <= sum_next;
`endif
        end else if (transfer) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stencil_window_gen.sv
// Testbench for stencil_window_gen: a 4x4 instance exercised by directed tables,
// stall/reset sequences and random handshakes against an image-array scoreboard,
// plus a 128x128 instance streaming one full frame.
`timescale 1ns/1ps
module tb_stencil_window_gen;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int PIX_W = 8;
    localparam int BIG_W = 128;
    localparam int BIG_H = 128;

    typedef struct {
        logic [9*PIX_W-1:0] win;
        logic [15:0]        x;
        logic [15:0]        y;
        logic [PIX_W+3:0]   sum;
    } win_t;

    typedef struct {
        logic       v;
        logic       rdy;
        logic [7:0] pix;
        logic       exp_in_ready;
        logic       exp_out_valid;
        logic       exp_fd;
    } vec_t;

    logic clk;
    logic rst;
    logic rst_big;
    logic rand_ready;

    int tests;
    int fails;

    win_t               exp_q [$];
    logic [9*PIX_W-1:0] captured [$];
    logic [PIX_W-1:0]   img [IMG_H][IMG_W];
    int mx, my;
    int win_count, fd_count;

    int big_count, big_bad, big_fd, big_last_x, big_last_y;
    logic [7:0] big_last_c;

    logic [71:0] ref_win;
    int ref_sum [4];

    stencil_window_if #(.PIX_W(PIX_W)) sif ();
    stencil_window_if #(.PIX_W(PIX_W)) bif ();

    stencil_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    stencil_window_gen #(.IMG_W(BIG_W), .IMG_H(BIG_H), .PIX_W(PIX_W)) dut_big (
        .clk (clk),
        .rst (rst_big),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    function automatic win_t model_window(input int cx, input int cy);
        win_t w;
        w.win = '0;
        w.sum = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w.win[PIX_W*(3*r+c) +: PIX_W] = img[cy-1+r][cx-1+c];
                w.sum = w.sum + (PIX_W+4)'(img[cy-1+r][cx-1+c]);
            end
        end
        w.x = 16'(cx);
        w.y = 16'(cy);
        return w;
    endfunction

    // Scoreboard for the small instance: pops on output transfer, pushes on pixel accept.
    always @(negedge clk) begin
        win_t e;
        logic fd_exp;
        if (rst) begin
            exp_q.delete();
            mx = 0;
            my = 0;
        end else begin
            fd_exp = 1'b0;
            if (sif.out_valid && sif.out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_window: got window at (%0d,%0d), want none", sif.out_x, sif.out_y);
                end else begin
                    e = exp_q.pop_front();
                    check_output("win", sif.out_win, e.win);
                    check_output("win_x", sif.out_x, e.x);
                    check_output("win_y", sif.out_y, e.y);
`ifdef STENCIL_SUM_EN
                    check_output("win_sum", sif.out_sum, e.sum);
`endif
                    fd_exp = (e.x == 16'(IMG_W - 2)) && (e.y == 16'(IMG_H - 2));
                    captured.push_back(sif.out_win);
                    win_count++;
                end
            end
            check_output("frame_done", sif.frame_done, fd_exp);
            if (sif.frame_done) fd_count++;
            if (sif.in_valid && sif.in_ready) begin
                img[my][mx] = sif.in_pixel;
                if (mx >= 2 && my >= 2) exp_q.push_back(model_window(mx - 1, my - 1));
                if (mx == IMG_W - 1) begin
                    mx = 0;
                    my = (my == IMG_H - 1) ? 0 : my + 1;
                end else begin
                    mx++;
                end
            end
        end
    end

    // Position/content tracker for the large instance.
    always @(negedge clk) begin
        int ex, ey;
        if (!rst_big) begin
            if (bif.out_valid && bif.out_ready) begin
                ex = 1 + big_count % (BIG_W - 2);
                ey = 1 + big_count / (BIG_W - 2);
                if (bif.out_x != 16'(ex) || bif.out_y != 16'(ey) ||
                    bif.out_win[8*4 +: 8] != 8'(ex + ey) ||
                    bif.out_win[7:0] != 8'(ex + ey - 2))
                    big_bad++;
                big_last_x = int'(bif.out_x);
                big_last_y = int'(bif.out_y);
                big_last_c = bif.out_win[8*4 +: 8];
                big_count++;
            end
            if (bif.frame_done) big_fd++;
        end
    end

    // Random downstream back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) sif.out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        sif.in_valid = 1'b1;
        sif.in_pixel = 8'hEE;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("rst_out_valid", sif.out_valid, 1'b0);
        check_output("rst_in_ready", sif.in_ready, 1'b1);
        check_output("rst_frame_done", sif.frame_done, 1'b0);
        check_output("rst_out_x", sif.out_x, 16'd0);
        check_output("rst_out_y", sif.out_y, 16'd0);
        check_output("rst_out_win", sif.out_win, '0);
`ifdef STENCIL_SUM_EN
        check_output("rst_out_sum", sif.out_sum, '0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        sif.in_valid = 1'b0;
        captured.delete();
        win_count = 0;
        fd_count = 0;
    endtask

    task automatic apply_stimulus(input logic [7:0] pix, input bit gaps);
        int wait_cycles;
        if (gaps) begin
            sif.in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        sif.in_valid = 1'b1;
        sif.in_pixel = pix;
        wait_cycles = 0;
        @(negedge clk);
        while (!sif.in_ready && wait_cycles < 100) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (!sif.in_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL send_timeout: in_ready got 0 for 100 cycles, want 1");
        end
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input string name);
        int c;
        c = 0;
        while (fd_count < n && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        check_output(name, fd_count, n);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reference(input string tag);
        int s;
        check_output({tag, "_count"}, win_count, 4);
        if (captured.size() > 0) check_output({tag, "_first_win"}, captured[0], ref_win);
        for (int k = 0; k < 4 && k < captured.size(); k++) begin
            s = 0;
            for (int b = 0; b < 9; b++) s += int'(captured[k][8*b +: 8]);
            check_output($sformatf("%s_sum%0d", tag, k), s, ref_sum[k]);
        end
    endtask

    initial begin
        vec_t tbl [18];
        int c;
        bit aborted;

        tests = 0;
        fails = 0;
        rand_ready = 1'b0;
        rst = 1'b1;
        rst_big = 1'b1;
        sif.in_valid = 1'b0;
        sif.in_pixel = '0;
        sif.out_ready = 1'b1;
        bif.in_valid = 1'b0;
        bif.in_pixel = '0;
        bif.out_ready = 1'b1;
        big_count = 0;
        big_bad = 0;
        big_fd = 0;
        big_last_x = 0;
        big_last_y = 0;
        big_last_c = '0;

        ref_win = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
        ref_sum = '{45, 54, 81, 90};

        for (int i = 0; i < 18; i++) begin
            tbl[i].v             = (i < 16);
            tbl[i].rdy           = 1'b1;
            tbl[i].pix           = 8'(i);
            tbl[i].exp_in_ready  = (i != 16);
            tbl[i].exp_out_valid = (i == 11 || i == 12 || i == 15 || i == 16);
            tbl[i].exp_fd        = (i == 16);
        end

        // Scenario 1: full-rate stream, cycle-by-cycle table.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            sif.in_valid  = tbl[i].v;
            sif.out_ready = tbl[i].rdy;
            sif.in_pixel  = tbl[i].pix;
            @(negedge clk);
            check_output($sformatf("s1_in_ready[%0d]", i), sif.in_ready, tbl[i].exp_in_ready);
            check_output($sformatf("s1_out_valid[%0d]", i), sif.out_valid, tbl[i].exp_out_valid);
            check_output($sformatf("s1_frame_done[%0d]", i), sif.frame_done, tbl[i].exp_fd);
            @(posedge clk);
            #1;
        end
        sif.in_valid = 1'b0;
        check_output("s1_fd_count", fd_count, 1);
        check_reference("s1");

        // Scenario 2: downstream stall right after the first window.
        do_reset();
        sif.out_ready = 1'b1;
        for (int i = 0; i <= 10; i++) apply_stimulus(8'(i), 1'b0);
        sif.out_ready = 1'b0;
        sif.in_valid = 1'b1;
        sif.in_pixel = 8'd11;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_output($sformatf("s2_in_ready[%0d]", k), sif.in_ready, 1'b0);
            check_output($sformatf("s2_out_valid[%0d]", k), sif.out_valid, 1'b1);
            check_output($sformatf("s2_out_win[%0d]", k), sif.out_win, ref_win);
            @(posedge clk);
            #1;
        end
        sif.out_ready = 1'b1;
        for (int i = 11; i < 16; i++) apply_stimulus(8'(i), 1'b0);
        wait_frames(1, "s2_frames");
        check_reference("s2");

        // Scenario 3: random gaps on both sides over three back-to-back frames.
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 48; i++) apply_stimulus(8'($urandom_range(0, 255)), 1'b1);
        wait_frames(3, "s3_frames");
        rand_ready = 1'b0;
        sif.out_ready = 1'b1;
        check_output("s3_win_count", win_count, 12);
        check_output("s3_queue_empty", exp_q.size(), 0);

        // Scenario 4: reset mid-frame, then a clean frame.
        do_reset();
        sif.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) apply_stimulus(8'($urandom_range(0, 255)), 1'b0);
        do_reset();
        for (int i = 0; i < 16; i++) apply_stimulus(8'(i), 1'b0);
        wait_frames(1, "s4_frames");
        check_reference("s4");

        // Scenario 6: hold the last window; the next frame must wait for frame_done.
        do_reset();
        sif.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) apply_stimulus(8'(i + 20), 1'b0);
        sif.out_ready = 1'b0;
        sif.in_valid = 1'b1;
        sif.in_pixel = 8'h77;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output($sformatf("s6_in_ready[%0d]", k), sif.in_ready, 1'b0);
            check_output($sformatf("s6_out_valid[%0d]", k), sif.out_valid, 1'b1);
            @(posedge clk);
            #1;
        end
        sif.out_ready = 1'b1;
        @(negedge clk);
        check_output("s6_in_ready_done", sif.in_ready, 1'b0);
        check_output("s6_frame_done", sif.frame_done, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("s6_in_ready_after", sif.in_ready, 1'b1);
        check_output("s6_fd_before_accept", fd_count, 1);
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
        for (int i = 1; i < 16; i++) apply_stimulus(8'(i + 40), 1'b0);
        wait_frames(2, "s6_frames");
        check_output("s6_win_count", win_count, 8);

        // Scenario 5: one full 128x128 frame of (x+y) pixels.
        @(posedge clk);
        #1;
        rst_big = 1'b0;
        aborted = 1'b0;
        for (int yy = 0; yy < BIG_H && !aborted; yy++) begin
            for (int xx = 0; xx < BIG_W && !aborted; xx++) begin
                bif.in_valid = 1'b1;
                bif.in_pixel = 8'(xx + yy);
                c = 0;
                @(negedge clk);
                while (!bif.in_ready && c < 20) begin
                    @(negedge clk);
                    c++;
                end
                if (!bif.in_ready) begin
                    tests++;
                    fails++;
                    aborted = 1'b1;
                    $display("[TB] FAIL big_send_timeout: in_ready got 0 at (%0d,%0d), want 1", xx, yy);
                end
                @(posedge clk);
                #1;
            end
        end
        bif.in_valid = 1'b0;
        c = 0;
        while (big_fd < 1 && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        check_output("big_win_count", big_count, 15876);
        check_output("big_last_x", big_last_x, 126);
        check_output("big_last_y", big_last_y, 126);
        check_output("big_last_centre", big_last_c, 8'hFC);
        check_output("big_bad_windows", big_bad, 0);
        check_output("big_frame_done", big_fd, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
